// File: rtl/flag_cmd_pkg.sv
// Shared definitions for the flag-command arbiter and its flag cells.
//   CMD_SET / CMD_CLR / CMD_HOLD : 2-bit command encodings (2'b11 also acts as HOLD)
//   IDX_W                        : width of the index returned by oh_to_idx
//   oh_to_idx                    : one-hot vector (up to 32 bits) to binary index
package flag_cmd_pkg;

    localparam logic [1:0] CMD_SET  = 2'b01;
    localparam logic [1:0] CMD_CLR  = 2'b10;
    localparam logic [1:0] CMD_HOLD = 2'b00;

    localparam int IDX_W = 5;

    // OR-reduction of the set bit positions; exact for a one-hot input,
    // returns 0 for an all-zero input.
    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [31:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/flag_cell.sv
// One flag bit of the flag-cell array.
//   clock, reset_n : clock and synchronous active-low reset
//   en             : apply cmd this cycle
//   cmd[1:0]       : SET / CLR / HOLD
//   q, q_n         : flag state and its inverse
module flag_cell
    import flag_cmd_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] cmd,
    output logic       q,
    output logic       q_n
);

    logic flag_q;
    logic flag_d;

    // Next flag value: only SET and CLR change the bit; both HOLD codes keep it.
    always_comb begin
        flag_d = flag_q;
        if (en) begin
            case (cmd)
                CMD_SET: flag_d = 1'b1;
                CMD_CLR: flag_d = 1'b0;
                default: flag_d = flag_q;
            endcase
        end else begin
            flag_d = flag_q;
        end
    end

    // Flag register with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign q   = flag_q;
    assign q_n = ~flag_q;

endmodule

// File: rtl/flag_cmd_arbiter.sv
// Round-robin arbiter sharing one set/clear command path between NREQ
// requesters; the issued command is applied one cycle later to one cell of
// an NCELL flag array.
//   clock, reset_n : clock and synchronous active-low reset
//   req/cmd/tgt    : per-requester request, 2-bit command, TW-bit target
//   gnt            : registered one-hot grant (one cycle)
//   cmd_vld/cmd_out/tgt_out : registered issued command
//   flags/flags_n  : flag array state and its inverse
//   err            : sticky out-of-range target indication
module flag_cmd_arbiter
    import flag_cmd_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NCELL = 2,
    parameter int TW    = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    cmd,
    input  logic [TW*NREQ-1:0]   tgt,
    output logic [NREQ-1:0]      gnt,
    output logic                 cmd_vld,
    output logic [1:0]           cmd_out,
    output logic [TW-1:0]        tgt_out,
    output logic [NCELL-1:0]     flags,
    output logic [NCELL-1:0]     flags_n,
    output logic                 err
);

    // Pointer width; oh_to_idx limits NREQ to 32.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             cmd_vld_q, cmd_vld_d;
    logic [1:0]       cmd_out_q, cmd_out_d;
    logic [TW-1:0]    tgt_out_q, tgt_out_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  elig_s;
    logic [NREQ-1:0]  win_oh_s;
    logic             found_s;
    logic [PW:0]      idx_s;
    logic [IDX_W-1:0] oh_idx_s;
    logic [PW-1:0]    win_idx_s;
    logic             tgt_oor_s;
    logic [NCELL-1:0] cell_en_s;

    // Round-robin search from ptr; last cycle's grantee is masked out.
    always_comb begin
        elig_s   = req & ~gnt_q;
        win_oh_s = '0;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx_s >= (PW+1)'(NREQ)) begin
                idx_s = idx_s - (PW+1)'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && elig_s[idx_s[PW-1:0]]) begin
                win_oh_s[idx_s[PW-1:0]] = 1'b1;
                found_s                 = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        oh_idx_s  = oh_to_idx(32'(win_oh_s));
        win_idx_s = oh_idx_s[PW-1:0];
    end

    // Issue registers, pointer advance and sticky error next-state.
    always_comb begin
        gnt_d     = '0;
        cmd_vld_d = 1'b0;
        cmd_out_d = cmd_out_q;
        tgt_out_d = tgt_out_q;
        ptr_d     = ptr_q;
        if (found_s) begin
            gnt_d     = win_oh_s;
            cmd_vld_d = 1'b1;
            cmd_out_d = cmd[32'd2 * 32'(win_idx_s) +: 2];
            tgt_out_d = tgt[32'(TW) * 32'(win_idx_s) +: TW];
            ptr_d     = (win_idx_s == PW'(NREQ - 1)) ? '0 : win_idx_s + 1'b1;
        end else begin
            gnt_d     = '0;
            cmd_vld_d = 1'b0;
        end
        // A target beyond the array is dropped by the cells and flagged here.
        tgt_oor_s = ({1'b0, tgt_out_q} >= (TW+1)'(NCELL));
        err_d     = err_q | (cmd_vld_q & tgt_oor_s);
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            gnt_q     <= '0;
            cmd_vld_q <= 1'b0;
            cmd_out_q <= 2'b00;
            tgt_out_q <= '0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_out_q <= cmd_out_d;
            tgt_out_q <= tgt_out_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
        end
    end

    // The issued command is applied by the addressed cell on the next edge.
    for (genvar i = 0; i < NCELL; i++) begin : g_cell
        assign cell_en_s[i] = cmd_vld_q && (tgt_out_q == TW'(i));

        flag_cell u_flag_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (cell_en_s[i]),
            .cmd     (cmd_out_q),
            .q       (flags[i]),
            .q_n     (flags_n[i])
        );
    end

    assign gnt     = gnt_q;
    assign cmd_vld = cmd_vld_q;
    assign cmd_out = cmd_out_q;
    assign tgt_out = tgt_out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_flag_cmd_arbiter.sv
// Scoreboard bench: dut_a has NCELL=2, dut_b has NCELL=1 (target 1 is out of
// range there). Both share stimulus so their grant streams must be identical.
module tb_flag_cmd_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req_r;
    logic [7:0] cmd_r;
    logic [3:0] tgt_r;

    logic [3:0] gnt_a, gnt_b;
    logic       cmd_vld_a, cmd_vld_b;
    logic [1:0] cmd_out_a, cmd_out_b;
    logic [0:0] tgt_out_a, tgt_out_b;
    logic [1:0] flags_a, flags_n_a;
    logic [0:0] flags_b, flags_n_b;
    logic       err_a, err_b;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] cmd;
        logic       tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    flag_cmd_arbiter #(.NREQ(4), .NCELL(2), .TW(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .req(req_r), .cmd(cmd_r), .tgt(tgt_r),
        .gnt(gnt_a), .cmd_vld(cmd_vld_a), .cmd_out(cmd_out_a), .tgt_out(tgt_out_a),
        .flags(flags_a), .flags_n(flags_n_a), .err(err_a)
    );

    flag_cmd_arbiter #(.NREQ(4), .NCELL(1), .TW(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .req(req_r), .cmd(cmd_r), .tgt(tgt_r),
        .gnt(gnt_b), .cmd_vld(cmd_vld_b), .cmd_out(cmd_out_b), .tgt_out(tgt_out_b),
        .flags(flags_b), .flags_n(flags_n_b), .err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] c, input logic t);
        exp_t x;
        x.gnt = g;
        x.cmd = c;
        x.tgt = t;
        exp_q.push_back(x);
    endtask

    // Monitor: pops one expected grant whenever a command is issued.
    always @(negedge clock) begin
        check("flags_n_a", {30'd0, flags_n_a}, {30'd0, ~flags_a});
        check("flags_n_b", {31'd0, flags_n_b}, {31'd0, ~flags_b});
        if (cmd_vld_a || cmd_vld_b) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: gnt_a=%b gnt_b=%b, expected no grant (t=%0t)",
                         gnt_a, gnt_b, $time);
            end else begin
                e_mon = exp_q.pop_front();
                check("cmd_vld_a", {31'd0, cmd_vld_a}, 32'd1);
                check("cmd_vld_b", {31'd0, cmd_vld_b}, 32'd1);
                check("gnt_a", {28'd0, gnt_a}, {28'd0, e_mon.gnt});
                check("gnt_b", {28'd0, gnt_b}, {28'd0, e_mon.gnt});
                check("cmd_out_a", {30'd0, cmd_out_a}, {30'd0, e_mon.cmd});
                check("cmd_out_b", {30'd0, cmd_out_b}, {30'd0, e_mon.cmd});
                check("tgt_out_a", {31'd0, tgt_out_a}, {31'd0, e_mon.tgt});
                check("tgt_out_b", {31'd0, tgt_out_b}, {31'd0, e_mon.tgt});
            end
        end else begin
            check("gnt_a_idle", {28'd0, gnt_a}, 32'd0);
            check("gnt_b_idle", {28'd0, gnt_b}, 32'd0);
        end
    end

    initial begin
        reset_n = 1'b0;
        req_r   = 4'hF;
        cmd_r   = 8'h55;
        tgt_r   = 4'h0;

        // Reset held for 3 edges with all requests up.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_gnt", {28'd0, gnt_a}, 32'd0);
        check("rst_cmd_vld", {31'd0, cmd_vld_a}, 32'd0);
        check("rst_flags", {30'd0, flags_a}, 32'd0);
        check("rst_flags_n", {30'd0, flags_n_a}, 32'd3);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_err_b", {31'd0, err_b}, 32'd0);
        req_r   = 4'h0;
        reset_n = 1'b1;

        // Round robin from ptr=0 with all requests held; HOLD codes 00 and 11.
        req_r = 4'hF;
        cmd_r = 8'b11_00_00_11;
        tgt_r = 4'h0;
        push(4'b0001, 2'b11, 1'b0);
        push(4'b0010, 2'b00, 1'b0);
        push(4'b0100, 2'b00, 1'b0);
        push(4'b1000, 2'b11, 1'b0);
        push(4'b0001, 2'b11, 1'b0);
        repeat (5) @(negedge clock);
        req_r = 4'h0;
        @(negedge clock);
        check("rr_flags_hold", {30'd0, flags_a}, 32'd0);
        check("rr_err_a", {31'd0, err_a}, 32'd0);
        check("rr_err_b", {31'd0, err_b}, 32'd0);

        // Single request: req2 SET cell1 (out of range for dut_b).
        req_r      = 4'b0100;
        cmd_r[5:4] = 2'b01;
        tgt_r[2]   = 1'b1;
        push(4'b0100, 2'b01, 1'b1);
        @(negedge clock);
        req_r = 4'h0;
        @(negedge clock);
        check("single_flags", {30'd0, flags_a}, 32'd2);
        check("single_flags_n", {30'd0, flags_n_a}, 32'd1);
        check("single_err_a", {31'd0, err_a}, 32'd0);
        check("oor_flags_b", {31'd0, flags_b}, 32'd0);
        check("oor_err_b", {31'd0, err_b}, 32'd1);

        // Ordering: req0 SET cell0 then req1 CLR cell0 (ptr=3 -> req0 first).
        req_r      = 4'b0011;
        cmd_r[1:0] = 2'b01;
        cmd_r[3:2] = 2'b10;
        tgt_r[0]   = 1'b0;
        tgt_r[1]   = 1'b0;
        push(4'b0001, 2'b01, 1'b0);
        push(4'b0010, 2'b10, 1'b0);
        @(negedge clock);
        req_r[0] = 1'b0;
        @(negedge clock);
        check("order_set_a", {30'd0, flags_a}, 32'd3);
        check("order_set_b", {31'd0, flags_b}, 32'd1);
        req_r[1] = 1'b0;
        @(negedge clock);
        check("order_clr_a", {30'd0, flags_a}, 32'd2);
        check("order_clr_b", {31'd0, flags_b}, 32'd0);
        check("err_b_sticky", {31'd0, err_b}, 32'd1);

        // Continuous req0: granted every other cycle only.
        req_r = 4'b0001;
        cmd_r = 8'h00;
        tgt_r = 4'h0;
        push(4'b0001, 2'b00, 1'b0);
        push(4'b0001, 2'b00, 1'b0);
        repeat (3) @(negedge clock);
        req_r = 4'h0;

        // Reset on the edge that would apply a SET: flags must not change.
        req_r      = 4'b0010;
        cmd_r[3:2] = 2'b01;
        push(4'b0010, 2'b01, 1'b0);
        @(negedge clock);
        req_r   = 4'h0;
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_flags", {30'd0, flags_a}, 32'd0);
        check("midrst_flags_b", {31'd0, flags_b}, 32'd0);
        check("midrst_gnt", {28'd0, gnt_a}, 32'd0);
        check("midrst_cmd_vld", {31'd0, cmd_vld_a}, 32'd0);
        check("midrst_err_b", {31'd0, err_b}, 32'd0);
        reset_n = 1'b1;

        // Pointer restarted at 0: req1 beats req3.
        req_r = 4'b1010;
        cmd_r = 8'h00;
        push(4'b0010, 2'b00, 1'b0);
        push(4'b1000, 2'b00, 1'b0);
        @(negedge clock);
        req_r[1] = 1'b0;
        @(negedge clock);
        req_r = 4'h0;
        repeat (2) @(negedge clock);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
